// File: rtl/y_adder.sv
// Registered WIDTH-bit ripple-carry adder with carry-in, carry-out, signed overflow
// and zero flags; one cycle of latency, strobed by out_valid.
module y_adder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] z,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             out_valid
);

    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             carry_msb;

    // Each cell owns its carry signals so the chain is a set of distinct nets
    // rather than one self-referencing vector.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        logic c_in;
        logic c_out;
        logic p;

        if (gi == 0) begin : g_first
            assign c_in = cin;
        end else begin : g_rest
            assign c_in = g_cell[gi-1].c_out;
        end

        assign p       = a[gi] ^ b[gi];
        assign sum[gi] = p ^ c_in;
        assign c_out   = (a[gi] & b[gi]) | (c_in & p);
    end

    assign carry_out = g_cell[WIDTH-1].c_out;
    assign carry_msb = g_cell[WIDTH-1].c_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z         <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                z    <= sum;
                cout <= carry_out;
                ovf  <= carry_out ^ carry_msb;
                zero <= ~|sum;
            end
        end
    end

endmodule

// File: tb/tb_y_adder.sv
// Self-checking bench for y_adder: directed vector table, randomized vectors
// against an arithmetic reference model, and reset/hold sequences.
module tb_y_adder;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] z;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         out_valid;

    int errors = 0;
    int checks = 0;

    y_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .z         (z),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] z;
        logic         cout;
        logic         ovf;
        logic         zero;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [W-1:0] ez, input logic ec,
                             input logic eo, input logic ezr, input logic ev);
        check({tag, ".z"},         64'(z),         64'(ez));
        check({tag, ".cout"},      64'(cout),      64'(ec));
        check({tag, ".ovf"},       64'(ovf),       64'(eo));
        check({tag, ".zero"},      64'(zero),      64'(ezr));
        check({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
    endtask

    // Reference: full-precision integer sum, signed overflow from operand/result signs.
    task automatic ref_add(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rc,
                           output logic [W-1:0] rz, output logic rcout,
                           output logic rovf, output logic rzero);
        longint unsigned full;
        full  = longint'(ra) + longint'(rb) + longint'(rc);
        rz    = full[W-1:0];
        rcout = full[W];
        rovf  = (ra[W-1] == rb[W-1]) && (rz[W-1] != ra[W-1]);
        rzero = (rz == '0);
    endtask

    initial begin
        logic [W-1:0] ez;
        logic         ec, eo, ezr;
        int           nerr;

        vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{32'h1234_5678, 32'h0FED_CBA8, 1'b1, 32'h2222_2221, 1'b0, 1'b0, 1'b0};

        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;

        #1;
        check_out("reset", '0, 1'b0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a        = vecs[i].a;
            b        = vecs[i].b;
            cin      = vecs[i].cin;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check_out($sformatf("vec%0d", i), vecs[i].z, vecs[i].cout, vecs[i].ovf,
                      vecs[i].zero, 1'b1);
        end

        // Back-to-back random operations with in_valid held high.
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            a        = $urandom;
            b        = (i % 6 == 5) ? ~a : $urandom;
            cin      = i[0];
            in_valid = 1'b1;
            ref_add(a, b, cin, ez, ec, eo, ezr);
            @(posedge clk);
            #1;
            nerr = errors;
            check_out($sformatf("rand%0d", i), ez, ec, eo, ezr, 1'b1);
            if (errors == nerr)
                $display("PASS rand%0d a=%h b=%h cin=%0b sum=%h", i, a, b, cin, {cout, z});
        end

        // Reset asserted between edges clears outputs without a clock edge.
        @(negedge clk);
        a        = 32'd1;
        b        = 32'd1;
        cin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check_out("pre_rst", 32'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_out("async_rst", '0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_out("rst_held", '0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_out("post_rst_idle", '0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Single valid cycle, then idle with changing operands: data holds.
        @(negedge clk);
        a        = 32'h0000_0005;
        b        = 32'h0000_0003;
        cin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check_out("hold_first", 32'h0000_0008, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            a        = $urandom;
            b        = $urandom;
            cin      = ~cin;
            @(posedge clk);
            #1;
            check_out($sformatf("hold%0d", i), 32'h0000_0008, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
